move_gen_ctrl: RTL and testbench
================================

MOVE_GEN_CTRL -- requirements
Module: move_gen_ctrl

Interface
Parameters:
REQ-001 PROP_CYCLES, 8, number of cycles newboard propagation is allowed to settle before draining starts; legal range 1..15.
REQ-002 NCOL, 8, number of column move FIFOs arbitrated; fixed at 8.
Ports:
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to generate moves for the currently loaded board.
REQ-006 newboard  output  1  broadcast to all square units, telling each one to launch its own piece.
REQ-007 col_empty  input  8  per-column FIFO empty flag; bit i is column i.
REQ-008 col_data  input  96  show-ahead FIFO heads; bits [12i+11:12i] are column i's move, formatted {from[5:0], to[5:0]}.
REQ-009 col_rd  output  8  one-hot pop strobe; the FIFO advances on the same edge.
REQ-010 mv_valid  output  1  mv_data holds a move.
REQ-011 mv_data  output  12  move {from, to}.
REQ-012 mv_ready  input  1  the consumer accepts mv_data when mv_valid and mv_ready are both high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse marking the end of generation.
REQ-015 move_count  output  8  number of moves accepted by the consumer in the last run; saturates at 255.

Function
REQ-016 The block SHALL implement a four-state FSM with states IDLE, LOAD, SETTLE and DRAIN.
REQ-017 IDLE -> LOAD SHALL occur when start=1; start SHALL be ignored in every other state.
REQ-018 In LOAD, newboard=1 for exactly one cycle; the FSM SHALL then move to SETTLE, clear the settle counter and clear move_count.
REQ-019 In SETTLE, the settle counter SHALL increment every cycle; after PROP_CYCLES cycles in SETTLE the FSM SHALL move to DRAIN; col_rd=0 throughout SETTLE.
REQ-020 In DRAIN, a pop SHALL be allowed in a cycle only when (!mv_valid || mv_ready) and at least one col_empty bit is 0.
REQ-021 The grant SHALL be round-robin: the search starts at the column after the last granted column, the pointer resets to 7 so column 0 wins first, and the pointer updates only on an actual pop.
REQ-022 When column g is popped, col_rd[g]=1 for that cycle only; on the next edge mv_data SHALL equal col_data[12g+11:12g] and mv_valid SHALL be 1.
REQ-023 If mv_valid && mv_ready and no pop occurs, mv_valid SHALL clear on the next edge.
REQ-024 col_rd SHALL have at most one bit set, and never a bit whose col_empty is 1.
REQ-025 move_count SHALL increment by 1 on each mv_valid && mv_ready cycle and SHALL hold at 255 once reached.
REQ-026 DRAIN -> IDLE SHALL occur when all col_empty=1, no pop occurs and (!mv_valid || mv_ready); done=1 for that one cycle; move_count SHALL hold until the next LOAD.
REQ-027 A stalled consumer (mv_ready=0) SHALL freeze mv_valid, mv_data and col_rd=0 with no loss or duplication of moves.
REQ-028 Latency from start to newboard SHALL be 1 cycle; from start to the first possible col_rd SHALL be PROP_CYCLES+2 cycles.
REQ-029 busy SHALL be 1 in LOAD, SETTLE and DRAIN and 0 in IDLE.

Reset
REQ-030 On reset=1 at a clock edge, all outputs SHALL go to 0 on that edge: newboard, col_rd, mv_valid, mv_data, busy, done and move_count.
REQ-031 On the same edge the FSM SHALL return to IDLE, the settle counter SHALL clear and the round-robin pointer SHALL go to 7.
REQ-032 Reset SHALL take priority over start and over any handshake in progress; a move held in the output register at reset SHALL be discarded.

Verification
REQ-033 PROP_CYCLES=8, start pulse at cycle 0 -> newboard=1 only at cycle 1; busy=1 from cycle 1; no col_rd before cycle 10.
REQ-034 Columns 0, 3 and 7 each hold 2 moves, mv_ready=1 -> pop order 0,3,7,0,3,7; done pulses once; move_count=6.
REQ-035 Column 2 holds 0x0A5 and 0x1C3, mv_ready held 0 for 5 cycles after the first pop -> mv_data=0x0A5 is stable for those 5 cycles; no second pop until mv_ready=1; both moves delivered in order.
REQ-036 All columns empty after SETTLE -> done pulses in the first DRAIN cycle; move_count=0; col_rd never asserted.
REQ-037 300 moves presented across the columns -> move_count=255 at done; all 300 moves delivered.
REQ-038 reset asserted during DRAIN with mv_valid=1 -> next cycle mv_valid=0, busy=0, FSM in IDLE; a new start restarts cleanly with column 0 granted first.

Source files
------------

// File: rtl/move_gen_ctrl.sv
// Move generator controller: launches a board, waits for propagation to settle,
// then drains eight column move FIFOs round-robin into one valid/ready move stream.
module move_gen_ctrl #(
  parameter int PROP_CYCLES = 8,
  parameter int NCOL        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              newboard,
  input  logic [NCOL-1:0]   col_empty,
  input  logic [12*NCOL-1:0] col_data,
  output logic [NCOL-1:0]   col_rd,
  output logic              mv_valid,
  output logic [11:0]       mv_data,
  input  logic              mv_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        move_count
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t      state_r;
  logic [3:0]  settle_cnt_r;
  logic [2:0]  rr_ptr_r;
  logic        newboard_r;
  logic        busy_r;
  logic        mv_valid_r;
  logic [11:0] mv_data_r;
  logic [7:0]  move_count_r;

  logic        can_take_s;
  logic        any_s;
  logic        pop_s;
  logic        finish_s;
  logic        accept_s;
  logic [2:0]  grant_s;
  logic [11:0] grant_data_s;

  // Round-robin pick: scanning from farthest to nearest lets the column just after rr_ptr_r win
  always_comb begin
    grant_s = rr_ptr_r;
    for (int i = NCOL; i >= 1; i--) begin
      grant_s = col_empty[3'(rr_ptr_r + 3'(i))] ? grant_s : 3'(rr_ptr_r + 3'(i));
    end
    grant_data_s = col_data[32'(grant_s) * 12 +: 12];
  end

  // Pop/finish decisions; col_rd and done must react to mv_ready in the same cycle
  always_comb begin
    any_s      = ~&col_empty;
    can_take_s = !mv_valid_r || mv_ready;
    accept_s   = mv_valid_r && mv_ready;
    pop_s      = (state_r == DRAIN) && can_take_s && any_s;
    finish_s   = (state_r == DRAIN) && can_take_s && !any_s;
    col_rd     = pop_s ? (NCOL'(1) << grant_s) : '0;
    done       = finish_s;
  end

  // Controller FSM with its registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      settle_cnt_r <= 4'd0;
      rr_ptr_r     <= 3'd7;
      newboard_r   <= 1'b0;
      busy_r       <= 1'b0;
      mv_valid_r   <= 1'b0;
      mv_data_r    <= 12'd0;
      move_count_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= LOAD;
            newboard_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        LOAD: begin
          newboard_r   <= 1'b0;
          settle_cnt_r <= 4'd0;
          move_count_r <= 8'd0;
          state_r      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_r == 4'(PROP_CYCLES - 1)) begin
            state_r <= DRAIN;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        DRAIN: begin
          if (pop_s) begin
            mv_valid_r <= 1'b1;
            mv_data_r  <= grant_data_s;
            rr_ptr_r   <= grant_s;
          end else if (accept_s) begin
            mv_valid_r <= 1'b0;
          end
          if (accept_s && move_count_r != 8'hFF) begin
            move_count_r <= move_count_r + 8'd1;
          end
          if (finish_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign newboard   = newboard_r;
  assign busy       = busy_r;
  assign mv_valid   = mv_valid_r;
  assign mv_data    = mv_data_r;
  assign move_count = move_count_r;
endmodule

// File: tb/tb_move_gen_ctrl.sv
// Bench for move_gen_ctrl: column FIFO models, a queue-based delivery-order
// reference, table-driven runs and hand-written stall/reset sequences.
module tb_move_gen_ctrl;
  localparam int PROP = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        newboard;
  logic [7:0]  col_empty;
  logic [95:0] col_data;
  logic [7:0]  col_rd;
  logic        mv_valid;
  logic [11:0] mv_data;
  logic        mv_ready;
  logic        busy;
  logic        done;
  logic [7:0]  move_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] fmem [8][512];
  int          fwr [8] = '{default: 0};
  int          frd [8] = '{default: 0};
  logic [11:0] mq [8][$];
  int          model_ptr = 7;
  int          pops [$];

  typedef struct {
    logic [7:0] mask;
    int         n;
    int         mode;
    int         exp_count;
  } vec_t;
  vec_t vecs [6];

  move_gen_ctrl #(.PROP_CYCLES(PROP), .NCOL(8)) dut (
    .clk(clk), .reset(reset), .start(start), .newboard(newboard),
    .col_empty(col_empty), .col_data(col_data), .col_rd(col_rd),
    .mv_valid(mv_valid), .mv_data(mv_data), .mv_ready(mv_ready),
    .busy(busy), .done(done), .move_count(move_count)
  );

  always #5 clk = ~clk;

  // Show-ahead column FIFOs
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      col_empty[i]        = (frd[i] == fwr[i]);
      col_data[12*i +: 12] = fmem[i][frd[i]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (col_rd[i]) frd[i] <= frd[i] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_move(input int c, input logic [11:0] d);
    fmem[c][fwr[c]] = d;
    fwr[c]++;
    mq[c].push_back(d);
  endtask

  // mode 0: always ready, 1: random ready + stray starts, 2: stall 5 cycles after first pop
  task automatic run_drain(input int mode, input int exp_count);
    logic [11:0] exp_q [$];
    int   acc, first_pop, done_cyc, dones, stall_left, after, budget, cyc;
    logic pv, pr, in_stall, legal;
    logic [11:0] pd;
    bit   any;
    // expected delivery order: serve the next non-empty column after the last one served
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        int c;
        c = (model_ptr + i) % 8;
        if (mq[c].size() > 0) begin
          exp_q.push_back(mq[c].pop_front());
          model_ptr = c;
          any = 1'b1;
          break;
        end
      end
    end
    pops.delete();
    acc = 0; first_pop = -1; done_cyc = -1; dones = 0; stall_left = 0; after = 0;
    pv = 1'b0; pr = 1'b0; pd = 12'd0;
    budget = 4 * exp_q.size() + 60;
    for (cyc = 0; cyc < budget && after < 3; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (mode == 1 && done_cyc < 0 && cyc >= 2 && $urandom_range(0, 3) == 0);
      case (mode)
        1:       mv_ready = ($urandom_range(0, 3) != 0);
        2:       mv_ready = (stall_left == 0);
        default: mv_ready = 1'b1;
      endcase
      in_stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      #1;
      check("newboard", newboard, cyc == 1);
      check("busy", busy, cyc >= 1 && done_cyc < 0);
      legal = ($countones(col_rd) <= 1) && ((col_rd & col_empty) == 8'd0);
      check("col_rd_legal", legal, 1'b1);
      if (cyc < PROP + 2) check("col_rd_early", col_rd, 8'd0);
      if (cyc >= 2) check("move_count", move_count, (acc > 255) ? 255 : acc);
      if (pv && !pr) begin
        check("stall_valid", mv_valid, 1'b1);
        check("stall_data", mv_data, pd);
      end
      if (mv_valid && !mv_ready) check("stall_no_pop", col_rd, 8'd0);
      if (mode == 2 && in_stall) check("stall_data_0a5", mv_data, 12'h0A5);
      if (col_rd != 8'd0) begin
        if (first_pop < 0) begin
          first_pop = cyc;
          if (mode == 2) stall_left = 5;
        end
        for (int j = 0; j < 8; j++) if (col_rd[j]) pops.push_back(j);
      end
      if (mv_valid && mv_ready) begin
        acc++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_move: got 0x%0h expected no further move", mv_data);
        end else begin
          check("move_data", mv_data, exp_q.pop_front());
        end
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc) after++;
      pv = mv_valid; pr = mv_ready; pd = mv_data;
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: done not seen within %0d cycles, expected a done pulse", budget);
    end
    check("done_pulses", dones, 1);
    check("moves_left", exp_q.size(), 0);
    check("final_count", move_count, exp_count);
    if (exp_count > 0) begin
      check("first_pop_cycle", first_pop, PROP + 2);
    end else begin
      check("empty_done_cycle", done_cyc, PROP + 2);
      check("no_pops", pops.size(), 0);
    end
  endtask

  initial begin
    int cols [$];
    int exp_order [6];
    exp_order = '{0, 3, 7, 0, 3, 7};
    vecs[0] = '{mask: 8'h89, n: 6,   mode: 0, exp_count: 6};
    vecs[1] = '{mask: 8'h00, n: 0,   mode: 0, exp_count: 0};
    vecs[2] = '{mask: 8'hFF, n: 300, mode: 0, exp_count: 255};
    vecs[3] = '{mask: 8'h5A, n: 40,  mode: 1, exp_count: 40};
    vecs[4] = '{mask: 8'hFF, n: 64,  mode: 1, exp_count: 64};
    vecs[5] = '{mask: 8'h01, n: 3,   mode: 1, exp_count: 3};

    reset = 1'b1; start = 1'b0; mv_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_newboard", newboard, 1'b0);
    check("rst_col_rd", col_rd, 8'd0);
    check("rst_mv_valid", mv_valid, 1'b0);
    check("rst_mv_data", mv_data, 12'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_move_count", move_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      cols.delete();
      for (int b = 0; b < 8; b++) if (vecs[v].mask[b]) cols.push_back(b);
      for (int j = 0; j < vecs[v].n; j++) push_move(cols[j % cols.size()], 12'($urandom_range(0, 4095)));
      run_drain(vecs[v].mode, vecs[v].exp_count);
      if (v == 0) begin
        check("grant_order_len", pops.size(), 6);
        for (int j = 0; j < 6; j++) if (j < pops.size()) check("grant_order", pops[j], exp_order[j]);
      end
    end

    // Consumer stall on column 2
    push_move(2, 12'h0A5);
    push_move(2, 12'h1C3);
    run_drain(2, 2);

    // Reset while a move is held in DRAIN, then restart
    for (int j = 0; j < 4; j++) push_move(1, 12'h300 + 12'(j));
    mv_ready = 1'b0;
    for (int w = 0; w < 30 && !mv_valid; w++) begin
      @(negedge clk);
      start = (w == 0);
      #1;
    end
    check("held_before_reset", mv_valid, 1'b1);
    @(negedge clk);
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    #1;
    check("rst2_mv_valid", mv_valid, 1'b0);
    check("rst2_busy", busy, 1'b0);
    check("rst2_newboard", newboard, 1'b0);
    check("rst2_col_rd", col_rd, 8'd0);
    check("rst2_move_count", move_count, 8'd0);
    void'(mq[1].pop_front());
    model_ptr = 7;
    push_move(0, 12'h0AA);
    push_move(0, 12'h0BB);
    run_drain(0, 5);
    check("restart_first_col", (pops.size() > 0) ? pops[0] : -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
